// File: rtl/locker_entry_conditioner.sv
`default_nettype none
// ============================================================================
// locker_entry_conditioner : synchronise and debounce the ENTER button and the
// combination switches, giving one enter pulse per press with frozen comb bits
// Rev 1.0
// ============================================================================
module locker_entry_conditioner #(
   parameter int SYNC_STAGES = 2,
   parameter int DB_WIDTH    = 16,
   parameter int DB_CYCLES   = 50000,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             raw_enter,
   input  logic             raw_comb1,
   input  logic             raw_comb2,
   output logic             enter,
   output logic             comb1,
   output logic             comb2,
   output logic [CNT_W-1:0] entry_count
);

   localparam logic [DB_WIDTH-1:0] c_db_last = DB_WIDTH'(DB_CYCLES - 1);
   localparam logic [DB_WIDTH-1:0] c_db_one  = DB_WIDTH'(1);
   localparam logic [CNT_W-1:0]    c_cnt_one = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_ARMING    = 3'd1,
      S_FIRE      = 3'd2,
      S_HELD      = 3'd3,
      S_RELEASING = 3'd4
   } state_t;

   logic [SYNC_STAGES-1:0] r_sync_enter;
   logic [SYNC_STAGES-1:0] r_sync_comb1;
   logic [SYNC_STAGES-1:0] r_sync_comb2;
   logic                   w_btn;
   logic [1:0]             w_sw_sync;
   logic [1:0]             r_sw_stable;
   logic [DB_WIDTH-1:0]    r_sw_cnt [2];
   state_t                 r_state;
   state_t                 w_state_next;
   logic [DB_WIDTH-1:0]    r_cnt;
   logic [DB_WIDTH-1:0]    w_cnt_next;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync_enter <= '0;
         r_sync_comb1 <= '0;
         r_sync_comb2 <= '0;
      end else begin
         r_sync_enter <= {r_sync_enter[SYNC_STAGES-2:0], raw_enter};
         r_sync_comb1 <= {r_sync_comb1[SYNC_STAGES-2:0], raw_comb1};
         r_sync_comb2 <= {r_sync_comb2[SYNC_STAGES-2:0], raw_comb2};
      end
   end

   assign w_btn        = r_sync_enter[SYNC_STAGES-1];
   assign w_sw_sync[0] = r_sync_comb1[SYNC_STAGES-1];
   assign w_sw_sync[1] = r_sync_comb2[SYNC_STAGES-1];

   // Each switch level only moves after DB_CYCLES consecutive disagreeing samples.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sw_stable <= '0;
         r_sw_cnt[0] <= '0;
         r_sw_cnt[1] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (w_sw_sync[i] == r_sw_stable[i]) begin
               r_sw_cnt[i] <= '0;
            end else if (r_sw_cnt[i] == c_db_last) begin
               r_sw_stable[i] <= w_sw_sync[i];
               r_sw_cnt[i]    <= '0;
            end else begin
               r_sw_cnt[i] <= r_sw_cnt[i] + c_db_one;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_btn) begin
               w_state_next = S_ARMING;
               w_cnt_next   = '0;
            end
         end
         S_ARMING: begin
            if (!w_btn) begin
               w_state_next = S_IDLE;
            end else if (r_cnt == c_db_last) begin
               w_state_next = S_FIRE;
            end else begin
               w_cnt_next = r_cnt + c_db_one;
            end
         end
         S_FIRE: begin
            w_state_next = S_HELD;
         end
         S_HELD: begin
            if (!w_btn) begin
               w_state_next = S_RELEASING;
               w_cnt_next   = '0;
            end
         end
         S_RELEASING: begin
            // A short return to pressed is a release bounce, not a new press.
            if (w_btn) begin
               w_state_next = S_HELD;
            end else if (r_cnt == c_db_last) begin
               w_state_next = S_IDLE;
            end else begin
               w_cnt_next = r_cnt + c_db_one;
            end
         end
         default: begin
            w_state_next = S_IDLE;
            w_cnt_next   = '0;
         end
      endcase
   end

   // Pulse, comb snapshot and count all update on the same edge so the locker
   // FSM sees consistent comb bits while enter is high.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         enter       <= 1'b0;
         comb1       <= 1'b0;
         comb2       <= 1'b0;
         entry_count <= '0;
      end else begin
         enter <= (r_state == S_FIRE);
         if (r_state == S_FIRE) begin
            comb1       <= r_sw_stable[0];
            comb2       <= r_sw_stable[1];
            entry_count <= entry_count + c_cnt_one;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_locker_entry_conditioner.sv
`default_nettype none
// ============================================================================
// tb_locker_entry_conditioner : scenario tasks plus a run-length reference model
// Rev 1.0
// ============================================================================
module tb_locker_entry_conditioner;

   localparam int SYNC_STAGES = 2;
   localparam int DB_WIDTH    = 16;
   localparam int DB_CYCLES   = 4;
   localparam int CNT_W       = 8;

   logic             clk       = 1'b0;
   logic             reset     = 1'b1;
   logic             raw_enter = 1'b0;
   logic             raw_comb1 = 1'b0;
   logic             raw_comb2 = 1'b0;
   logic             enter;
   logic             comb1;
   logic             comb2;
   logic [CNT_W-1:0] entry_count;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   locker_entry_conditioner #(
      .SYNC_STAGES(SYNC_STAGES),
      .DB_WIDTH   (DB_WIDTH),
      .DB_CYCLES  (DB_CYCLES),
      .CNT_W      (CNT_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .raw_enter  (raw_enter),
      .raw_comb1  (raw_comb1),
      .raw_comb2  (raw_comb2),
      .enter      (enter),
      .comb1      (comb1),
      .comb2      (comb2),
      .entry_count(entry_count)
   );

   // Reference model: an input is seen SYNC_STAGES edges after it is sampled;
   // a press is accepted after DB_CYCLES+1 consecutive high sightings, a release
   // after DB_CYCLES+1 consecutive lows; a switch flips after DB_CYCLES
   // consecutive disagreeing sightings. The pulse follows acceptance by one edge.
   logic             d_btn [SYNC_STAGES];
   logic             d_sw1 [SYNC_STAGES];
   logic             d_sw2 [SYNC_STAGES];
   logic             seen_btn;
   logic             seen_sw [2];
   logic             m_pressed, m_skip, m_fire;
   int               hi_run, lo_run;
   logic             m_stable [2];
   int               diff_run [2];
   logic             exp_enter, exp_comb1, exp_comb2;
   logic [CNT_W-1:0] exp_count;

   initial begin
      forever begin
         @(posedge clk or negedge reset);
         if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
               d_btn[i] = 1'b0;
               d_sw1[i] = 1'b0;
               d_sw2[i] = 1'b0;
            end
            m_pressed = 1'b0; m_skip = 1'b0; m_fire = 1'b0;
            hi_run = 0; lo_run = 0;
            m_stable[0] = 1'b0; m_stable[1] = 1'b0;
            diff_run[0] = 0; diff_run[1] = 0;
            exp_enter = 1'b0; exp_comb1 = 1'b0; exp_comb2 = 1'b0;
            exp_count = '0;
         end else begin
            seen_btn   = d_btn[SYNC_STAGES-1];
            seen_sw[0] = d_sw1[SYNC_STAGES-1];
            seen_sw[1] = d_sw2[SYNC_STAGES-1];
            for (int i = SYNC_STAGES - 1; i > 0; i--) begin
               d_btn[i] = d_btn[i-1];
               d_sw1[i] = d_sw1[i-1];
               d_sw2[i] = d_sw2[i-1];
            end
            d_btn[0] = raw_enter;
            d_sw1[0] = raw_comb1;
            d_sw2[0] = raw_comb2;
            exp_enter = m_fire;
            if (m_fire) begin
               exp_comb1 = m_stable[0];
               exp_comb2 = m_stable[1];
               exp_count = exp_count + CNT_W'(1);
            end
            m_fire = 1'b0;
            for (int i = 0; i < 2; i++) begin
               if (seen_sw[i] != m_stable[i]) begin
                  diff_run[i]++;
                  if (diff_run[i] == DB_CYCLES) begin
                     m_stable[i] = seen_sw[i];
                     diff_run[i] = 0;
                  end
               end else begin
                  diff_run[i] = 0;
               end
            end
            if (!m_pressed) begin
               hi_run = seen_btn ? hi_run + 1 : 0;
               if (hi_run == DB_CYCLES + 1) begin
                  m_pressed = 1'b1; m_fire = 1'b1; m_skip = 1'b1; lo_run = 0;
               end
            end else if (m_skip) begin
               m_skip = 1'b0;
            end else begin
               lo_run = seen_btn ? 0 : lo_run + 1;
               if (lo_run == DB_CYCLES + 1) begin
                  m_pressed = 1'b0; hi_run = 0;
               end
            end
         end
      end
   end

   logic [CNT_W+2:0] obs, expv;
   assign obs  = {enter, comb1, comb2, entry_count};
   assign expv = {exp_enter, exp_comb1, exp_comb2, exp_count};

   typedef struct packed {
      logic e;
      logic c1;
      logic c2;
   } stim_t;
   stim_t pat[$];

   function automatic void add(input int n, input logic e, input logic c1, input logic c2);
      stim_t s;
      s.e = e; s.c1 = c1; s.c2 = c2;
      for (int i = 0; i < n; i++) pat.push_back(s);
   endfunction

   task automatic test_reset();
      reset = 1'b0;
      raw_enter = 1'b0; raw_comb1 = 1'b0; raw_comb2 = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (obs !== '0) begin
         failures++; $display("FAIL reset_outputs got=%h exp=0", obs);
      end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (obs !== '0) begin
         failures++; $display("FAIL reset_release got=%h exp=0", obs);
      end
   endtask

   task automatic test_clean_press();
      int first = -1;
      int np    = 0;
      pat.delete();
      add(20, 1, 0, 0);
      add(20, 0, 0, 0);
      foreach (pat[t]) begin
         raw_enter = pat[t].e; raw_comb1 = pat[t].c1; raw_comb2 = pat[t].c2;
         @(negedge clk);
         checks++;
         if (obs !== expv) begin
            failures++; $display("FAIL clean_model t=%0d got=%h exp=%h", t, obs, expv);
         end
         if (enter === 1'b1) begin
            np++;
            if (first < 0) first = t;
         end
      end
      checks++;
      if (first !== 7) begin failures++; $display("FAIL clean_latency got=%0d exp=7", first); end
      checks++;
      if (np !== 1) begin failures++; $display("FAIL clean_pulses got=%0d exp=1", np); end
      checks++;
      if (entry_count !== 8'd1) begin failures++; $display("FAIL clean_count got=%0d exp=1", entry_count); end
   endtask

   task automatic test_bounce();
      int first = -1;
      int np    = 0;
      pat.delete();
      add(3, 1, 0, 0);
      add(1, 0, 0, 0);
      add(12, 1, 0, 0);
      add(20, 0, 0, 0);
      foreach (pat[t]) begin
         raw_enter = pat[t].e; raw_comb1 = pat[t].c1; raw_comb2 = pat[t].c2;
         @(negedge clk);
         checks++;
         if (obs !== expv) begin
            failures++; $display("FAIL bounce_model t=%0d got=%h exp=%h", t, obs, expv);
         end
         if (enter === 1'b1) begin
            np++;
            if (first < 0) first = t;
         end
      end
      checks++;
      if (first !== 11) begin failures++; $display("FAIL bounce_latency got=%0d exp=11", first); end
      checks++;
      if (np !== 1) begin failures++; $display("FAIL bounce_pulses got=%0d exp=1", np); end
      checks++;
      if (entry_count !== 8'd2) begin failures++; $display("FAIL bounce_count got=%0d exp=2", entry_count); end
   endtask

   task automatic test_long_hold();
      int ptimes[$];
      pat.delete();
      add(100, 1, 0, 0);
      add(2, 0, 0, 0);
      add(10, 1, 0, 0);
      add(20, 0, 0, 0);
      add(10, 1, 0, 0);
      add(20, 0, 0, 0);
      foreach (pat[t]) begin
         raw_enter = pat[t].e; raw_comb1 = pat[t].c1; raw_comb2 = pat[t].c2;
         @(negedge clk);
         checks++;
         if (obs !== expv) begin
            failures++; $display("FAIL hold_model t=%0d got=%h exp=%h", t, obs, expv);
         end
         if (enter === 1'b1) ptimes.push_back(t);
      end
      checks++;
      if (ptimes.size() != 2 || ptimes[0] != 7 || ptimes[1] != 139) begin
         failures++;
         $display("FAIL hold_pulses got n=%0d first=%0d last=%0d exp n=2 at 7,139", ptimes.size(),
                  (ptimes.size() > 0) ? ptimes[0] : -1, (ptimes.size() > 0) ? ptimes[$] : -1);
      end
      checks++;
      if (entry_count !== 8'd4) begin failures++; $display("FAIL hold_count got=%0d exp=4", entry_count); end
   endtask

   task automatic test_switches();
      logic cap1[$];
      logic cap2[$];
      pat.delete();
      for (int k = 0; k < 10; k++) begin
         add(2, 0, 1, 0);
         add(1, 0, 1, 1);
      end
      add(10, 1, 1, 0);
      add(20, 0, 1, 0);
      add(10, 0, 0, 0);
      add(10, 1, 0, 0);
      add(20, 0, 0, 0);
      foreach (pat[t]) begin
         raw_enter = pat[t].e; raw_comb1 = pat[t].c1; raw_comb2 = pat[t].c2;
         @(negedge clk);
         checks++;
         if (obs !== expv) begin
            failures++; $display("FAIL switch_model t=%0d got=%h exp=%h", t, obs, expv);
         end
         if (enter === 1'b1) begin
            cap1.push_back(comb1);
            cap2.push_back(comb2);
         end
      end
      checks++;
      if (cap1.size() != 2) begin
         failures++; $display("FAIL switch_pulses got=%0d exp=2", cap1.size());
      end else begin
         checks++;
         if (cap1[0] !== 1'b1 || cap2[0] !== 1'b0) begin
            failures++; $display("FAIL switch_capture1 got c1=%0b c2=%0b exp c1=1 c2=0", cap1[0], cap2[0]);
         end
         checks++;
         if (cap1[1] !== 1'b0) begin
            failures++; $display("FAIL switch_capture2 got c1=%0b exp c1=0", cap1[1]);
         end
      end
   endtask

   task automatic test_reset_mid_arming();
      int np    = 0;
      int first = -1;
      raw_enter = 1'b1; raw_comb1 = 1'b0; raw_comb2 = 1'b0;
      for (int t = 0; t < 5; t++) begin
         @(negedge clk);
         checks++;
         if (obs !== expv) begin
            failures++; $display("FAIL midrst_arm t=%0d got=%h exp=%h", t, obs, expv);
         end
         if (enter === 1'b1) np++;
      end
      reset = 1'b0;
      #1;
      checks++;
      if (obs !== '0) begin failures++; $display("FAIL midrst_async got=%h exp=0", obs); end
      repeat (2) @(negedge clk);
      checks++;
      if (obs !== '0) begin failures++; $display("FAIL midrst_held got=%h exp=0", obs); end
      reset = 1'b1;
      for (int t = 0; t < 40; t++) begin
         raw_enter = (t < 20);
         @(negedge clk);
         checks++;
         if (obs !== expv) begin
            failures++; $display("FAIL midrst_model t=%0d got=%h exp=%h", t, obs, expv);
         end
         if (enter === 1'b1) begin
            np++;
            if (first < 0) first = t;
         end
      end
      checks++;
      if (np !== 1 || first !== 7) begin
         failures++; $display("FAIL midrst_pulse got n=%0d at=%0d exp n=1 at=7", np, first);
      end
      checks++;
      if (entry_count !== 8'd1) begin failures++; $display("FAIL midrst_count got=%0d exp=1", entry_count); end
   endtask

   task automatic test_wrap();
      int total = 0;
      reset = 1'b0;
      raw_enter = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (entry_count !== '0) begin failures++; $display("FAIL wrap_start got=%0d exp=0", entry_count); end
      for (int p = 0; p < 256; p++) begin
         int hi_len = $urandom_range(10, 6);
         int lo_len = $urandom_range(10, 7);
         int np     = 0;
         raw_comb1 = 1'($urandom_range(1, 0));
         raw_comb2 = 1'($urandom_range(1, 0));
         for (int t = 0; t < hi_len + lo_len; t++) begin
            raw_enter = (t < hi_len);
            @(negedge clk);
            checks++;
            if (obs !== expv) begin
               failures++; $display("FAIL wrap_model p=%0d t=%0d got=%h exp=%h", p, t, obs, expv);
            end
            if (enter === 1'b1) np++;
         end
         total += np;
         checks++;
         if (np !== 1) begin failures++; $display("FAIL wrap_press p=%0d got=%0d exp=1", p, np); end
      end
      checks++;
      if (entry_count !== '0 || total !== 256) begin
         failures++; $display("FAIL wrap_end got count=%0d pulses=%0d exp count=0 pulses=256", entry_count, total);
      end
   endtask

   task automatic test_random();
      int   rem_e = 0, rem_1 = 0, rem_2 = 0;
      logic prev  = 1'b0;
      for (int t = 0; t < 3000; t++) begin
         if (rem_e == 0) begin raw_enter = 1'($urandom_range(1, 0)); rem_e = $urandom_range(12, 1); end
         if (rem_1 == 0) begin raw_comb1 = 1'($urandom_range(1, 0)); rem_1 = $urandom_range(8, 1); end
         if (rem_2 == 0) begin raw_comb2 = 1'($urandom_range(1, 0)); rem_2 = $urandom_range(8, 1); end
         rem_e--; rem_1--; rem_2--;
         @(negedge clk);
         checks++;
         if (obs !== expv) begin
            failures++; $display("FAIL random_model t=%0d got=%h exp=%h", t, obs, expv);
         end
         if (prev && enter === 1'b1) begin
            checks++; failures++;
            $display("FAIL random_double_pulse t=%0d got=11 exp=10", t);
         end
         prev = (enter === 1'b1);
      end
   endtask

   initial begin
      #1;
      test_reset();
      test_clean_press();
      test_bounce();
      test_long_hold();
      test_switches();
      test_reset_mid_arming();
      test_wrap();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
